alu_cmd_dispatcher: RTL and testbench

Command front-end that sits directly upstream of the 8-bit ALU. It accepts operand/opcode commands over a valid/ready stream and buffers them in a small FIFO. It drives the ALU start/done handshake one command at a time and returns each 16-bit result over a valid/ready response stream. It also sequences ALU reset commands and recovers from an ALU that never asserts done.

---
 rtl/def_pkg.sv | 38 +++
 rtl/alu_cmd_dispatcher_if.sv | 36 +++
 rtl/alu_cmd_dispatcher_fifo.sv | 56 +++++
 rtl/alu_cmd_dispatcher.sv | 171 +++++++++++++++++
 tb/tb_alu_cmd_dispatcher.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/def_pkg.sv
// Shared ALU definitions: opcode encoding, dispatcher states and the queued command record.
package def_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'd0,
        add_op = 3'd1,
        and_op = 3'd2,
        xor_op = 3'd3,
        mul_op = 3'd4,
        rst_op = 3'd7
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        NOP,
        RESET
    } dispatch_state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        operation_t op;
    } alu_cmd_t;

    // Unused encodings 5 and 6 collapse onto no_op so downstream logic only sees legal values.
    function automatic operation_t decode_op(input logic [2:0] code);
        case (code)
            3'd1:    return add_op;
            3'd2:    return and_op;
            3'd3:    return xor_op;
            3'd4:    return mul_op;
            3'd7:    return rst_op;
            default: return no_op;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmd_dispatcher_if.sv
// Command stream, response stream and ALU handshake signals of the dispatcher.
interface alu_cmd_dispatcher_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  cmd_op;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;

    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_rst_n;
    logic        alu_done;
    logic [15:0] alu_result;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
        output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err,
               alu_A, alu_B, alu_op, alu_start, alu_rst_n
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
        input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err,
               alu_A, alu_B, alu_op, alu_start, alu_rst_n
    );

endinterface

// File: rtl/alu_cmd_dispatcher_fifo.sv
// Power-of-two command FIFO holding alu_cmd_t entries; full/empty come from a registered occupancy count.
module alu_cmd_fifo
    import def_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  alu_cmd_t wr_data,
    input  logic     pop,
    output alu_cmd_t rd_data,
    output logic     empty,
    output logic     full
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_dispatcher.sv
// Buffers ALU commands, runs the ALU start/done handshake one command at a time and returns results,
// sequencing ALU resets and aborting commands whose done never arrives.
module alu_cmd_dispatcher
    import def_pkg::*;
#(
    parameter int CMD_DEPTH    = 4,
    parameter int DONE_TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 rst,
    alu_cmd_dispatcher_if.slave bus
);

    localparam int             TW           = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(DONE_TIMEOUT - 1);
    localparam logic [TW-1:0]  RESET_LAST   = TW'(1);

    dispatch_state_t state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic            alu_start_q, alu_start_d;
    logic            alu_rst_n_q, alu_rst_n_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_result_q, rsp_result_d;
    logic [2:0]      rsp_op_q, rsp_op_d;
    logic            rsp_err_q, rsp_err_d;

    alu_cmd_t        head;
    alu_cmd_t        wr_cmd;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full;

    assign wr_cmd = '{a: bus.cmd_a, b: bus.cmd_b, op: decode_op(bus.cmd_op)};

    alu_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.cmd_valid && !fifo_full),
        .wr_data (wr_cmd),
        .pop     (fifo_pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign bus.cmd_ready  = !fifo_full;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.alu_A      = alu_a_q;
    assign bus.alu_B      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_start  = alu_start_q;
    assign bus.alu_rst_n  = alu_rst_n_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        alu_start_d  = alu_start_q;
        alu_rst_n_d  = 1'b1;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        rsp_err_d    = rsp_err_q;
        fifo_pop     = 1'b0;

        // A consumed response frees the slot; a completion later in this block may refill it.
        if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                alu_start_d = 1'b0;
                if (!fifo_empty) begin
                    if (head.op == rst_op) begin
                        fifo_pop    = 1'b1;
                        alu_rst_n_d = 1'b0;
                        timer_d     = '0;
                        state_d     = RESET;
                    end else if (head.op == no_op) begin
                        fifo_pop    = 1'b1;
                        alu_a_d     = head.a;
                        alu_b_d     = head.b;
                        alu_op_d    = no_op;
                        alu_start_d = 1'b1;
                        state_d     = NOP;
                    end else if (!rsp_valid_q) begin
                        fifo_pop    = 1'b1;
                        alu_a_d     = head.a;
                        alu_b_d     = head.b;
                        alu_op_d    = head.op;
                        alu_start_d = 1'b1;
                        timer_d     = '0;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.alu_done) begin
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = bus.alu_result;
                    rsp_op_d     = alu_op_q;
                    rsp_err_d    = 1'b0;
                    alu_start_d  = 1'b0;
                    state_d      = IDLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    rsp_valid_d  = 1'b1;
                    rsp_result_d = '0;
                    rsp_op_d     = alu_op_q;
                    rsp_err_d    = 1'b1;
                    alu_start_d  = 1'b0;
                    alu_rst_n_d  = 1'b0;
                    timer_d      = '0;
                    state_d      = RESET;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            NOP: begin
                alu_start_d = 1'b0;
                state_d     = IDLE;
            end
            RESET: begin
                // The timer doubles as the two-cycle ALU reset counter.
                if (timer_q == RESET_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    alu_rst_n_d = 1'b0;
                    timer_d     = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_start_q  <= 1'b0;
            alu_rst_n_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            alu_start_q  <= alu_start_d;
            alu_rst_n_q  <= alu_rst_n_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_dispatcher.sv
// Self-checking bench for alu_cmd_dispatcher: a behavioural ALU, a response scoreboard,
// a table of arithmetic vectors and hand-written multi-cycle sequences.
module tb_alu_cmd_dispatcher;
    import def_pkg::*;

    localparam int CMD_DEPTH    = 4;
    localparam int DONE_TIMEOUT = 16;
    localparam int ALU_LAT      = 3;

    typedef struct {
        logic [15:0] result;
        logic [2:0]  op;
        logic        err;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  op;
        logic [15:0] result;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alu_enable = 1'b1;
    int   alu_cnt = 0;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   rsp_count = 0;
    int   start_hi_cnt = 0;
    int   rstn_lo_cnt = 0;
    int   pulse_run = 0;
    int   pulse_q[$];
    exp_t exp_q[$];
    vec_t vecs[6];

    always #5 clk = ~clk;

    alu_cmd_dispatcher_if bus();

    alu_cmd_dispatcher #(
        .CMD_DEPTH    (CMD_DEPTH),
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd1:    return 16'(a) + 16'(b);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural ALU: done pulses ALU_LAT cycles after start rises, unless disabled.
    always @(posedge clk) begin
        if (rst || !bus.alu_start || bus.alu_done) begin
            alu_cnt        <= 0;
            bus.alu_done   <= 1'b0;
            bus.alu_result <= 16'h0000;
        end else if (alu_cnt == ALU_LAT - 1) begin
            if (alu_enable) begin
                bus.alu_done   <= 1'b1;
                bus.alu_result <= alu_model(bus.alu_A, bus.alu_B, bus.alu_op);
            end
        end else begin
            alu_cnt <= alu_cnt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every accepted response is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.alu_start) start_hi_cnt++;
            if (!bus.alu_rst_n) rstn_lo_cnt++;
            if (bus.alu_start) pulse_run++;
            else if (pulse_run != 0) begin
                pulse_q.push_back(pulse_run);
                pulse_run = 0;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_rsp: got result %0h op %0d err %0b, required no response",
                             bus.rsp_result, bus.rsp_op, bus.rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rsp_result", 32'(bus.rsp_result), 32'(e.result));
                    checkOutput("rsp_op", 32'(bus.rsp_op), 32'(e.op));
                    checkOutput("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                 input bit expect_rsp, input logic [15:0] exp_result, input bit exp_err);
        bit accepted = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                accepted = 1'b1;
                if (expect_rsp) begin
                    e.result = exp_result;
                    e.op     = op;
                    e.err    = exp_err;
                    exp_q.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        if (!accepted) checkOutput("cmd_accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int first_start, first_rsp, s0, r0, c0, p0, accepted, low_seen;
        exp_t e;

        vecs[0] = '{a: 8'hFF, b: 8'hFF, op: 3'd4, result: 16'hFE01};
        vecs[1] = '{a: 8'hF0, b: 8'h3C, op: 3'd2, result: 16'h0030};
        vecs[2] = '{a: 8'hAA, b: 8'h55, op: 3'd3, result: 16'h00FF};
        vecs[3] = '{a: 8'h12, b: 8'h34, op: 3'd1, result: 16'h0046};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, op: 3'd1, result: 16'h01FE};
        vecs[5] = '{a: 8'h10, b: 8'h10, op: 3'd4, result: 16'h0100};

        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.cmd_op    = 3'd0;
        bus.rsp_ready = 1'b0;

        // Reset state, sampled while rst is still high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        checkOutput("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
        checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("rst_alu_A", 32'(bus.alu_A), 32'd0);
        checkOutput("rst_alu_B", 32'(bus.alu_B), 32'd0);
        checkOutput("rst_alu_op", 32'(bus.alu_op), 32'd0);
        checkOutput("rst_alu_start", 32'(bus.alu_start), 32'd0);
        checkOutput("rst_alu_rst_n_low", 32'(bus.alu_rst_n), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("alu_rst_n_after_rst", 32'(bus.alu_rst_n), 32'd1);

        // add FF+01 with latency measurement from the accepting edge.
        bus.rsp_ready = 1'b1;
        applyStimulus(8'hFF, 8'h01, 3'd1, 1'b1, 16'h0100, 1'b0);
        first_start = 0;
        first_rsp   = 0;
        for (int k = 1; k <= 40 && first_rsp == 0; k++) begin
            @(negedge clk);
            if (bus.alu_start && first_start == 0) begin
                first_start = k;
                checkOutput("alu_A_at_start", 32'(bus.alu_A), 32'hFF);
                checkOutput("alu_B_at_start", 32'(bus.alu_B), 32'h01);
            end
            if (bus.rsp_valid && first_rsp == 0) begin
                first_rsp = k;
                checkOutput("start_low_at_rsp", 32'(bus.alu_start), 32'd0);
            end
        end
        checkOutput("start_latency", 32'(first_start), 32'd2);
        checkOutput("rsp_latency", 32'(first_rsp), 32'(2 + ALU_LAT + 1));
        @(negedge clk);
        checkOutput("start_gap_after_rsp", 32'(bus.alu_start), 32'd0);
        waitDrain(50);

        // Table of arithmetic vectors, queued back to back.
        c0 = rsp_count;
        for (int i = 0; i < 6; i++)
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, vecs[i].result, 1'b0);
        waitDrain(200);
        checkOutput("table_rsp_count", 32'(rsp_count - c0), 32'd6);

        // Fill with the response slot blocked: one in flight plus CMD_DEPTH queued.
        bus.rsp_ready = 1'b0;
        accepted = 0;
        c0 = rsp_count;
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            bus.cmd_valid = (accepted < 10);
            bus.cmd_a     = 8'(accepted);
            bus.cmd_b     = 8'h01;
            bus.cmd_op    = 3'd1;
            @(negedge clk);
            if (bus.cmd_valid && bus.cmd_ready) begin
                e.result = 16'(accepted) + 16'd1;
                e.op     = 3'd1;
                e.err    = 1'b0;
                exp_q.push_back(e);
                accepted++;
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("fill_accepted", 32'(accepted), 32'(CMD_DEPTH + 1));
        checkOutput("fill_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("fill_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        waitDrain(200);
        checkOutput("fill_rsp_count", 32'(rsp_count - c0), 32'(CMD_DEPTH + 1));

        // Done never arrives: abort, two-cycle ALU reset, then the queued command issues.
        alu_enable = 1'b0;
        s0 = start_hi_cnt;
        r0 = rstn_lo_cnt;
        applyStimulus(8'h01, 8'h02, 3'd1, 1'b1, 16'h0000, 1'b1);
        applyStimulus(8'h0F, 8'hF0, 3'd3, 1'b1, 16'h00FF, 1'b0);
        first_rsp = 0;
        for (int k = 0; k < 60 && first_rsp == 0; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) first_rsp = 1;
        end
        checkOutput("timeout_rsp_seen", 32'(first_rsp), 32'd1);
        checkOutput("timeout_start_cycles", 32'(start_hi_cnt - s0), 32'(DONE_TIMEOUT));
        low_seen = 0;
        for (int k = 0; k < 10 && !bus.alu_rst_n; k++) @(negedge clk);
        alu_enable = 1'b1;
        checkOutput("timeout_rst_n_back_high", 32'(bus.alu_rst_n), 32'd1);
        checkOutput("timeout_rst_n_low_cycles", 32'(rstn_lo_cnt - r0), 32'd2);
        @(negedge clk);
        checkOutput("next_cmd_issues", 32'(bus.alu_start), 32'd1);
        waitDrain(100);

        // no_op, rst_op, xor: only the xor yields a response.
        c0 = rsp_count;
        r0 = rstn_lo_cnt;
        p0 = pulse_q.size();
        applyStimulus(8'h00, 8'h00, 3'd0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(8'h00, 8'h00, 3'd7, 1'b0, 16'h0000, 1'b0);
        applyStimulus(8'hAA, 8'h55, 3'd3, 1'b1, 16'h00FF, 1'b0);
        waitDrain(100);
        checkOutput("seq_pulse_count", 32'(pulse_q.size() - p0), 32'd2);
        if (pulse_q.size() >= p0 + 2) begin
            checkOutput("seq_nop_pulse_len", 32'(pulse_q[p0]), 32'd1);
            checkOutput("seq_xor_pulse_len", 32'(pulse_q[p0 + 1]), 32'(ALU_LAT + 1));
        end
        checkOutput("seq_rst_n_low_cycles", 32'(rstn_lo_cnt - r0), 32'd2);
        checkOutput("seq_rsp_count", 32'(rsp_count - c0), 32'd1);

        // Reset while ISSUE waits with three commands queued.
        alu_enable = 1'b0;
        for (int i = 0; i < 4; i++)
            applyStimulus(8'(i), 8'h01, 3'd1, 1'b0, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_in_issue", 32'(bus.alu_start), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        alu_enable = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("mid_rst_alu_start", 32'(bus.alu_start), 32'd0);
        s0 = start_hi_cnt;
        c0 = rsp_count;
        @(negedge clk);
        checkOutput("mid_rst_alu_rst_n", 32'(bus.alu_rst_n), 32'd1);
        repeat (30) @(negedge clk);
        checkOutput("mid_rst_no_issue", 32'(start_hi_cnt - s0), 32'd0);
        checkOutput("mid_rst_no_rsp", 32'(rsp_count - c0), 32'd0);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
